// File: rtl/if_id_stage.sv
// IF/ID pipeline register: holds the fetched instruction, its PC and PC+8, a fetch
// address exception code, a delay-slot tag and a saturating stall-cycle counter.
module if_id_stage #(
   parameter logic [31:0] PC_BASE  = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 1024,
   parameter logic [4:0]  EXC_ADEL = 5'd4
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] Instr_F,
   input  logic [31:0] PC_F,
   input  logic [31:0] PC8_F,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC8_D,
   output logic [4:0]  ExcCode_D,
   output logic        BD_D,
   output logic        Valid_D,
   output logic [31:0] StallCnt
);

   // Address of the last word in instruction memory; anything above it faults.
   localparam logic [31:0] PC_LAST = PC_BASE + 32'(4 * IM_WORDS) - 32'd4;

   logic        fetch_exc;
   logic        id_is_branch;
   logic [31:0] stall_cnt;

   assign fetch_exc = (PC_F[1:0] != 2'b00) || (PC_F < PC_BASE) || (PC_F > PC_LAST);
   assign StallCnt  = stall_cnt;

   // Branch/jump decode of the instruction currently held in ID (pre-update value).
   always_comb begin
      id_is_branch = 1'b0;
      unique case (Instr_D[31:26])
         6'b000001, 6'b000010, 6'b000011, 6'b000100,
         6'b000101, 6'b000110, 6'b000111:
            id_is_branch = 1'b1;
         6'b000000:
            id_is_branch = (Instr_D[5:0] == 6'b001000) || (Instr_D[5:0] == 6'b001001);
         default:
            id_is_branch = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         Instr_D   <= '0;
         PC_D      <= PC_BASE;
         PC8_D     <= PC_BASE + 32'd8;
         ExcCode_D <= '0;
         BD_D      <= 1'b0;
         Valid_D   <= 1'b0;
      end else if (flush) begin
         // PC still loads on a flush so the exception unit sees a usable EPC.
         Instr_D   <= '0;
         PC_D      <= PC_F;
         PC8_D     <= PC8_F;
         ExcCode_D <= '0;
         BD_D      <= 1'b0;
         Valid_D   <= 1'b0;
      end else if (!stall) begin
         Instr_D   <= fetch_exc ? '0 : Instr_F;
         PC_D      <= PC_F;
         PC8_D     <= PC8_F;
         ExcCode_D <= fetch_exc ? EXC_ADEL : '0;
         BD_D      <= Valid_D && id_is_branch;
         Valid_D   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset)
         stall_cnt <= '0;
      else if (stall && !flush && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 32'd1;
   end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: a cycle-level reference model predicts ID contents,
// the driver queues predictions and a monitor compares them after each clock edge.
module tb_if_id_stage;

   localparam logic [31:0] BASE  = 32'h0000_3000;
   localparam int unsigned WORDS = 1024;
   localparam logic [4:0]  ADEL  = 5'd4;

   logic        clk, Reset, stall, flush;
   logic [31:0] Instr_F, PC_F, PC8_F;
   logic [31:0] Instr_D, PC_D, PC8_D, StallCnt;
   logic [4:0]  ExcCode_D;
   logic        BD_D, Valid_D;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
      logic [4:0]  exc;
      logic        bd;
      logic        valid;
      logic [31:0] cnt;
   } id_t;

   id_t m;
   id_t expq[$];
   int  tests = 0;
   int  fails = 0;

   if_id_stage #(.PC_BASE(BASE), .IM_WORDS(WORDS), .EXC_ADEL(ADEL)) dut (
      .clk(clk), .Reset(Reset), .stall(stall), .flush(flush),
      .Instr_F(Instr_F), .PC_F(PC_F), .PC8_F(PC8_F),
      .Instr_D(Instr_D), .PC_D(PC_D), .PC8_D(PC8_D), .ExcCode_D(ExcCode_D),
      .BD_D(BD_D), .Valid_D(Valid_D), .StallCnt(StallCnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit is_cti(input logic [31:0] w);
      int op = int'(w[31:26]);
      int fn = int'(w[5:0]);
      if (op >= 1 && op <= 7) return 1'b1;
      return (op == 0) && (fn == 8 || fn == 9);
   endfunction

   function automatic bit bad_addr(input logic [31:0] pc);
      longint a = longint'(pc);
      return (a % 4 != 0) || (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * longint'(WORDS));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs at negedge, advance the model, queue its prediction.
   task automatic step(input bit r, input bit s, input bit f, input logic [31:0] instr,
                       input logic [31:0] pc, input bit deposit = 1'b0);
      @(negedge clk);
      if (deposit) begin
         dut.stall_cnt = 32'hFFFF_FFFE;
         m.cnt = 32'hFFFF_FFFE;
      end
      Reset = r; stall = s; flush = f; Instr_F = instr; PC_F = pc; PC8_F = pc + 32'd8;
      if (r) begin
         m.instr = '0; m.pc = BASE; m.pc8 = BASE + 32'd8; m.exc = '0;
         m.bd = 1'b0; m.valid = 1'b0; m.cnt = '0;
      end else if (f) begin
         m.instr = '0; m.pc = pc; m.pc8 = pc + 32'd8; m.exc = '0;
         m.bd = 1'b0; m.valid = 1'b0;
      end else if (s) begin
         if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 1;
      end else begin
         m.bd = m.valid && is_cti(m.instr);
         m.valid = 1'b1;
         m.pc = pc; m.pc8 = pc + 32'd8;
         if (bad_addr(pc)) begin
            m.instr = '0; m.exc = ADEL;
         end else begin
            m.instr = instr; m.exc = '0;
         end
      end
      expq.push_back(m);
   endtask

   initial begin : monitor
      id_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("Instr_D", Instr_D, e.instr);
            chk("PC_D", PC_D, e.pc);
            chk("PC8_D", PC8_D, e.pc8);
            chk("ExcCode_D", 32'(ExcCode_D), 32'(e.exc));
            chk("BD_D", 32'(BD_D), 32'(e.bd));
            chk("Valid_D", 32'(Valid_D), 32'(e.valid));
            chk("StallCnt", StallCnt, e.cnt);
         end
      end
   end

   initial begin : driver
      logic [31:0] pc, instr;
      int k;
      Reset = 1'b1; stall = 1'b0; flush = 1'b0; Instr_F = '0; PC_F = BASE; PC8_F = BASE + 8;
      step(1, 0, 0, 32'h3C01_0001, 32'h3000);
      step(1, 1, 1, 32'h3C01_0001, 32'h3000);
      step(0, 0, 0, 32'h3C01_0001, 32'h3000);
      step(0, 0, 0, 32'h1022_0003, 32'h3004);            // beq
      repeat (3) step(0, 1, 0, 32'h2001_0005, 32'h3008);
      step(0, 0, 0, 32'h2001_0005, 32'h3008);            // delay slot
      step(0, 0, 0, 32'h2002_0006, 32'h300C);
      step(0, 1, 1, 32'h2003_0007, 32'h300C);
      step(0, 0, 0, 32'h2004_0008, 32'h3002);
      step(0, 0, 0, 32'h2005_0009, 32'h3FFC);
      step(0, 0, 0, 32'h2006_000A, 32'h4000);
      step(0, 0, 0, 32'h2007_000B, 32'h2FFC);
      step(0, 0, 0, 32'h03E0_0008, 32'h3010);            // jr $31
      step(0, 0, 1, 32'h2008_000C, 32'h3014);
      step(0, 0, 0, 32'h2009_000D, 32'h3018);
      step(0, 1, 0, 32'h200A_000E, 32'h301C, 1'b1);
      repeat (3) step(0, 1, 0, 32'h200A_000E, 32'h301C);
      step(1, 1, 0, 32'h200A_000E, 32'h301C);
      for (int i = 0; i < 2000; i++) begin
         k = int'($urandom_range(0, 9));
         case (k)
            0: pc = BASE + 32'(4 * WORDS) - 32'd4;
            1: pc = BASE + 32'(4 * WORDS);
            2: pc = BASE - 32'd4;
            3: pc = BASE + 32'($urandom_range(0, 4095)) | 32'd1;
            4: pc = $urandom;
            default: pc = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
         endcase
         instr = $urandom;
         if ($urandom_range(0, 2) == 0) instr[31:26] = 6'($urandom_range(0, 7));
         if ($urandom_range(0, 4) == 0) instr[5:0] = 6'($urandom_range(8, 9));
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), instr, pc);
      end
      repeat (3) @(posedge clk);
      #2;
      tests++;
      if (expq.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d predictions left, expected 0", expq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
IF/ID pipeline register sitting directly downstream of the instruction fetch unit. It captures the fetched instruction and its PC/PC+8 each cycle. It supports stall (hold) and flush (bubble insertion), detects fetch address exceptions, and tags branch delay-slot instructions. It presents registered fetch results to the decode stage and to the hazard unit, and keeps a saturating stall-cycle counter for debug.

Parameters:
PC_BASE, 32'h0000_3000, byte address of instruction memory word 0 (reset PC)
IM_WORDS, 1024, number of 32-bit words in instruction memory
EXC_ADEL, 5'd4, exception code for an instruction fetch address error

Ports:
clk  input  1  clock, all state updates on posedge
Reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit hold request; 1 = keep current ID contents
flush  input  1  replace ID contents with a bubble (exception/eret redirect)
Instr_F  input  32  instruction from fetch stage
PC_F  input  32  PC of Instr_F
PC8_F  input  32  PC_F+8 from fetch stage (link address)
Instr_D  output  32  registered instruction for decode
PC_D  output  32  registered PC
PC8_D  output  32  registered link address
ExcCode_D  output  5  0 = none, EXC_ADEL = fetch address error
BD_D  output  1  1 = instruction in ID is in a branch delay slot
Valid_D  output  1  1 = ID holds a real fetched instruction, 0 = bubble
StallCnt  output  32  saturating count of stalled cycles

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values: Instr_D=0, PC_D=PC_BASE, PC8_D=PC_BASE+8, ExcCode_D=0, BD_D=0, Valid_D=0, StallCnt=0.
- Update priority each posedge: Reset > flush > stall > load.
- Flush, whether or not stall is asserted:
  - Instr_D=0 (NOP), ExcCode_D=0, BD_D=0, Valid_D=0.
  - PC_D and PC8_D load PC_F/PC8_F so the exception unit has a valid EPC source.
- Stall without flush: every output register holds its value.
- Load (no Reset/flush/stall): capture PC_F and PC8_F; set Valid_D=1.
- Fetch exception, evaluated combinationally on PC_F, is raised when PC_F[1:0]!=0, or PC_F<PC_BASE, or PC_F>PC_BASE+4*IM_WORDS-4.
  - On load with an exception: Instr_D=0 and ExcCode_D=EXC_ADEL. The instruction word is discarded.
  - On load without an exception: Instr_D=Instr_F and ExcCode_D=0.
- Delay slot: on load, BD_D=1 iff Valid_D=1 and the current Instr_D is a branch/jump. Branch/jump decode:
  - opcode 000001 (regimm), 000010 (j), 000011 (jal), 000100 (beq), 000101 (bne), 000110 (blez), 000111 (bgtz)
  - opcode 000000 with funct 001000 (jr) or 001001 (jalr)
  - Decode uses the pre-update Instr_D, so a branch held across N stall cycles still tags exactly the next loaded instruction.
- StallCnt increments by 1 on each posedge where stall=1, flush=0 and Reset=0. It saturates at 32'hFFFF_FFFF, with no wrap. It holds otherwise and is cleared only by Reset.
- Latency: inputs appear on outputs one cycle after a load edge. No combinational path from inputs to outputs.
- Reset asserted mid-stall or mid-flush: the reset values win on that edge. StallCnt is not incremented on that edge.
- A PC_F boundary value of exactly PC_BASE+4*IM_WORDS-4 is legal. PC_BASE+4*IM_WORDS raises the exception.

Test Plan:
- Reset then release with PC_F=0x3000, Instr_F=0x3C010001 → the cycle after, Instr_D=0x3C010001, PC_D=0x3000, PC8_D=0x3008, Valid_D=1, ExcCode_D=0; during reset all outputs equal the reset values.
- Load beq 0x10220003 at 0x3004, then hold stall=1 for 3 cycles while PC_F=0x3008 → outputs frozen for 3 cycles and StallCnt=3. Release → Instr_D = instr at 0x3008 and BD_D=1. The next load gives BD_D=0.
- flush=1 together with stall=1, PC_F=0x300C → Instr_D=0, Valid_D=0, BD_D=0, PC_D=0x300C, StallCnt unchanged.
- PC_F=0x3002 → ExcCode_D=4 and Instr_D=0. PC_F=0x3FFC → no exception. PC_F=0x4000 → ExcCode_D=4. PC_F=0x2FFC → ExcCode_D=4.
- jr $31 (0x03E00008) followed by a flush then a load → BD_D=0 for the loaded instruction, because the ID stage held a bubble.
- Force StallCnt to 0xFFFFFFFE via hierarchical deposit, then stall 3 cycles → StallCnt=0xFFFFFFFF and stays there. Reset clears it to 0.
